nn_layer_scheduler: RTL

- Command-driven controller sitting in front of the bit-serial hidden-layer engine.
- Executes two commands: LOAD, which streams N_HIDDEN*N_IN weights into the engine's weight-write port, and RUN, which admits exactly cmd_count feature vectors into the engine and counts the hidden-activation vectors that come back.
- Regenerates feature tlast on the N_IN-th element and flags malformed input vectors.
- Signals completion with a one-cycle pulse.

---
 rtl/nn_layer_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/nn_layer_scheduler.sv
// rtl/nn_layer_scheduler.sv - command-driven LOAD/RUN controller for the bit-serial hidden-layer engine
module nn_layer_scheduler #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int N_HIDDEN = 64,
    parameter int VCNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [VCNT_W-1:0]           cmd_count,
    input  logic [DATA_W-1:0]           s_wt_tdata,
    input  logic                        s_wt_tvalid,
    output logic                        s_wt_tready,
    output logic                        w_wr_en,
    output logic [$clog2(N_HIDDEN)-1:0] w_addr_h,
    output logic [$clog2(N_IN)-1:0]     w_addr_i,
    output logic [DATA_W-1:0]           w_data,
    input  logic [DATA_W-1:0]           s_feat_tdata,
    input  logic                        s_feat_tvalid,
    input  logic                        s_feat_tlast,
    output logic                        s_feat_tready,
    output logic [DATA_W-1:0]           eng_tdata,
    output logic                        eng_tvalid,
    output logic                        eng_tlast,
    input  logic                        eng_tready,
    input  logic                        eng_busy,
    input  logic                        mon_tvalid,
    input  logic                        mon_tready,
    input  logic                        mon_tlast,
    output logic [1:0]                  state_o,
    output logic                        done_pulse,
    output logic                        err_tlast,
    output logic [VCNT_W-1:0]           vec_out_cnt
);
    localparam int HW = $clog2(N_HIDDEN);
    localparam int IW = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic              done_d;
    logic [VCNT_W-1:0] cnt_q;
    logic [VCNT_W-1:0] fed_cnt;
    logic [HW-1:0]     h;
    logic [IW-1:0]     i;
    logic [IW-1:0]     e;
    logic              cmd_acc;
    logic              wt_hs;
    logic              feat_hs;
    logic              mon_hs;
    logic              feed_open;
    logic              last_wt;
    logic              last_vec_out;

    assign cmd_ready    = (state == ST_IDLE) & ~eng_busy;
    assign cmd_acc      = cmd_valid & cmd_ready;
    assign s_wt_tready  = (state == ST_LOAD);
    assign wt_hs        = s_wt_tvalid & s_wt_tready;
    assign last_wt      = (h == HW'(N_HIDDEN - 1)) && (i == IW'(N_IN - 1));

    // The gate closes once cmd_count vectors are in, so fed_cnt never wraps
    assign feed_open     = (state == ST_RUN) && (fed_cnt < cnt_q);
    assign eng_tvalid    = s_feat_tvalid & feed_open;
    assign s_feat_tready = eng_tready & feed_open;
    assign eng_tdata     = s_feat_tdata;
    assign eng_tlast     = (e == IW'(N_IN - 1));
    assign feat_hs       = eng_tvalid & eng_tready;

    // Output vectors are only counted while a RUN is active
    assign mon_hs       = (state == ST_RUN) & mon_tvalid & mon_tready & mon_tlast;
    assign last_vec_out = ((vec_out_cnt + VCNT_W'(1)) == cnt_q);
    assign state_o      = state;

    // State register and registered completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            done_pulse <= done_d;
        end
    end

    // Next-state and completion decode
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (!cmd_op) begin
                        state_d = ST_LOAD;
                    end else if (cmd_count != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (wt_hs && last_wt) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (mon_hs && last_vec_out) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Weight write port: one-cycle registered copy of each weight handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            w_wr_en  <= 1'b0;
            w_data   <= '0;
            w_addr_h <= '0;
            w_addr_i <= '0;
            h        <= '0;
            i        <= '0;
        end else begin
            w_wr_en <= wt_hs;
            if (cmd_acc) begin
                h <= '0;
                i <= '0;
            end else if (wt_hs) begin
                w_data   <= s_wt_tdata;
                w_addr_h <= h;
                w_addr_i <= i;
                if (i == IW'(N_IN - 1)) begin
                    i <= '0;
                    h <= h + HW'(1);
                end else begin
                    i <= i + IW'(1);
                end
            end
        end
    end

    // RUN bookkeeping: element/vector counters, tlast check, output vector count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            fed_cnt     <= '0;
            e           <= '0;
            vec_out_cnt <= '0;
            err_tlast   <= 1'b0;
        end else if (cmd_acc) begin
            cnt_q       <= cmd_count;
            fed_cnt     <= '0;
            e           <= '0;
            vec_out_cnt <= '0;
            err_tlast   <= 1'b0;
        end else begin
            if (feat_hs) begin
                if (eng_tlast) begin
                    e       <= '0;
                    fed_cnt <= fed_cnt + VCNT_W'(1);
                end else begin
                    e <= e + IW'(1);
                end
                if (s_feat_tlast != eng_tlast) begin
                    err_tlast <= 1'b1;
                end
            end
            if (mon_hs) begin
                vec_out_cnt <= vec_out_cnt + VCNT_W'(1);
            end
        end
    end
endmodule
